reg_page_ctrl: RTL and testbench

// - Parametrised register-page (play-area) controller for the R.O.E register file.
// - Holds the current page, forms full register addresses for NUM_PORTS operand ports as {page, lower}.
// - Adds a LIFO page stack so subroutines can switch play area and return to the caller's page.
// - Sits between instruction decode (page ops, short register fields) and register-file address inputs.

---
 rtl/roe_regdec_pkg.sv | 19 +
 rtl/page_stack.sv | 54 +++++
 rtl/reg_page_ctrl.sv | 135 +++++++++++++
 tb/tb_reg_page_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/roe_regdec_pkg.sv
// Shared types and helpers for the R.O.E register-address decode path.
// Contents:
//   PAGE_W_DEF / LOW_W_DEF  default page and lower-field widths
//   page_t / lower_t        default-width page and lower register fields
//   addr_cat()              forms a full register address {page, lower}
package roe_regdec_pkg;

    localparam int PAGE_W_DEF = 2;
    localparam int LOW_W_DEF  = 2;
    localparam int ADDR_W_DEF = PAGE_W_DEF + LOW_W_DEF;

    typedef logic [PAGE_W_DEF-1:0] page_t;
    typedef logic [LOW_W_DEF-1:0]  lower_t;

    function automatic logic [ADDR_W_DEF-1:0] addr_cat(page_t page, lower_t lower);
        return {page, lower};
    endfunction

endpackage

// File: rtl/page_stack.sv
// LIFO of saved register pages. Never wraps: a push while full and a
// pop while empty are ignored, so no stored entry is ever overwritten.
// Ports:
//   clk, reset  clock, synchronous active-high reset (clears count and contents)
//   push, pop   store din / discard top entry (caller never asserts both)
//   din         page to save
//   dout        current top entry (0 when empty)
//   depth       occupied entries
//   full/empty  occupancy status
module page_stack #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    cnt;

    assign depth = cnt;
    assign full  = (cnt == DW'(DEPTH));
    assign empty = (cnt == '0);

    // Entry index compared against the count rather than used as an
    // address, so the count width never has to match the array index width.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++)
                if (cnt == DW'(i)) mem[i] <= din;
            cnt <= cnt + DW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - DW'(1);
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++)
            if (cnt == DW'(i + 1)) dout = mem[i];
    end

endmodule

// File: rtl/reg_page_ctrl.sv
// Register-page (play-area) controller. Holds the current page and forms
// registered full addresses {page_nxt, lower_i} for NUM_PORTS operand ports.
// The address uses the page taking effect this cycle (bypass), so a page
// switch and the operand fetch that depends on it can issue together.
// Optional page stack (macro ROE_PAGE_STACK_EN) lets subroutines switch
// play area and return to the caller's page.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   set_pa_en/set_pa_val  load a new page
//   push/pop              save / restore page on the stack
//   lower_addr            packed per-port lower fields, port i at [i*LOW_W +: LOW_W]
//   reg_addr              registered full addresses, port i at [i*AW +: AW]
//   cur_page              registered current page
//   depth                 occupied stack entries
//   ovf/unf/op_err        1-cycle pulses: push on full, pop on empty, push with pop
module reg_page_ctrl
    import roe_regdec_pkg::*;
#(
    parameter int PAGE_W      = PAGE_W_DEF,
    parameter int LOW_W       = LOW_W_DEF,
    parameter int NUM_PORTS   = 2,
    parameter int STACK_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                set_pa_en,
    input  logic [PAGE_W-1:0]                   set_pa_val,
    input  logic                                push,
    input  logic                                pop,
    input  logic [NUM_PORTS*LOW_W-1:0]          lower_addr,
    output logic [NUM_PORTS*(PAGE_W+LOW_W)-1:0] reg_addr,
    output logic [PAGE_W-1:0]                   cur_page,
    output logic [$clog2(STACK_DEPTH+1)-1:0]    depth,
    output logic                                ovf,
    output logic                                unf,
    output logic                                op_err
);

    localparam int AW = PAGE_W + LOW_W;
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [PAGE_W-1:0]       page_nxt;
    logic [PAGE_W-1:0]       page_sel;
    logic [NUM_PORTS*AW-1:0] addr_nxt;
    logic                    ovf_nxt, unf_nxt, err_nxt;

    // Page chosen when no stack operation claims the cycle.
    assign page_sel = set_pa_en ? set_pa_val : cur_page;

`ifdef ROE_PAGE_STACK_EN
    logic              stk_push, stk_pop;
    logic [PAGE_W-1:0] stk_dout;
    logic [DW-1:0]     stk_depth;
    logic              stk_full, stk_empty;

    // The stack always saves the old page; a push with set_pa_en is a
    // call into a new area, a successful pop is the return and wins over set_pa_en.
    always_comb begin
        page_nxt = page_sel;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        ovf_nxt  = 1'b0;
        unf_nxt  = 1'b0;
        err_nxt  = 1'b0;
        if (push && pop) begin
            err_nxt = 1'b1;
        end else if (pop) begin
            if (!stk_empty) begin
                page_nxt = stk_dout;
                stk_pop  = 1'b1;
            end else begin
                unf_nxt = 1'b1;
            end
        end else if (push) begin
            if (!stk_full) stk_push = 1'b1;
            else           ovf_nxt  = 1'b1;
        end
    end

    page_stack #(
        .WIDTH (PAGE_W),
        .DEPTH (STACK_DEPTH),
        .DW    (DW)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (cur_page),
        .dout  (stk_dout),
        .depth (stk_depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign depth = stk_depth;
`else
    logic unused_stack_ops;
    assign unused_stack_ops = push ^ pop;

    assign page_nxt = page_sel;
    assign ovf_nxt  = 1'b0;
    assign unf_nxt  = 1'b0;
    assign err_nxt  = 1'b0;
    assign depth    = '0;
`endif

    // Per-port address formation; the package helper covers the default
    // field widths, other widths concatenate directly.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        if (PAGE_W == PAGE_W_DEF && LOW_W == LOW_W_DEF) begin : g_def
            assign addr_nxt[g*AW +: AW] =
                addr_cat(page_t'(page_nxt), lower_t'(lower_addr[g*LOW_W +: LOW_W]));
        end else begin : g_gen
            assign addr_nxt[g*AW +: AW] = {page_nxt, lower_addr[g*LOW_W +: LOW_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_page <= '0;
            reg_addr <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            op_err   <= 1'b0;
        end else begin
            cur_page <= page_nxt;
            reg_addr <= addr_nxt;
            ovf      <= ovf_nxt;
            unf      <= unf_nxt;
            op_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_reg_page_ctrl.sv
module tb_reg_page_ctrl;

    localparam int PAGE_W = 2;
    localparam int LOW_W  = 2;
    localparam int NP     = 2;
    localparam int SD     = 4;
    localparam int DW     = $clog2(SD + 1);
    localparam int AW     = PAGE_W + LOW_W;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 set_pa_en;
    logic [PAGE_W-1:0]    set_pa_val;
    logic                 push, pop;
    logic [NP*LOW_W-1:0]  lower_addr;
    logic [NP*AW-1:0]     reg_addr;
    logic [PAGE_W-1:0]    cur_page;
    logic [DW-1:0]        depth;
    logic                 ovf, unf, op_err;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_page;
    int m_stack[$];
    int m_ovf, m_unf, m_err;
    int m_addr;

    reg_page_ctrl #(.PAGE_W(PAGE_W), .LOW_W(LOW_W), .NUM_PORTS(NP), .STACK_DEPTH(SD)) dut (
        .clk        (clk),
        .reset      (reset),
        .set_pa_en  (set_pa_en),
        .set_pa_val (set_pa_val),
        .push       (push),
        .pop        (pop),
        .lower_addr (lower_addr),
        .reg_addr   (reg_addr),
        .cur_page   (cur_page),
        .depth      (depth),
        .ovf        (ovf),
        .unf        (unf),
        .op_err     (op_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: page selection rules applied to a queue-based stack.
    task automatic model(input bit r, input bit se, input int sv, input bit ps,
                         input bit pp, input int lw);
        int sel;
        if (r) begin
            m_page = 0; m_stack.delete(); m_ovf = 0; m_unf = 0; m_err = 0; m_addr = 0;
            return;
        end
        m_ovf = 0; m_unf = 0; m_err = 0;
        sel = se ? sv : m_page;
`ifdef ROE_PAGE_STACK_EN
        if (ps && pp) begin
            m_err = 1; m_page = sel;
        end else if (pp) begin
            if (m_stack.size() > 0) m_page = m_stack.pop_back();
            else begin m_unf = 1; m_page = sel; end
        end else if (ps) begin
            if (m_stack.size() < SD) m_stack.push_back(m_page);
            else m_ovf = 1;
            m_page = sel;
        end else begin
            m_page = sel;
        end
`else
        m_page = sel;
`endif
        m_addr = 0;
        for (int i = 0; i < NP; i++)
            m_addr += (m_page * (1 << LOW_W) + ((lw >> (i*LOW_W)) % (1 << LOW_W))) << (i*AW);
    endtask

    task automatic step(input string tag, input bit r, input bit se, input int sv,
                        input bit ps, input bit pp, input int lw);
        reset = r; set_pa_en = se; set_pa_val = PAGE_W'(sv);
        push = ps; pop = pp; lower_addr = (NP*LOW_W)'(lw);
        @(posedge clk);
        model(r, se, sv, ps, pp, lw);
        #1;
        chk({tag, ".page"},  int'(cur_page), m_page);
        chk({tag, ".addr"},  int'(reg_addr), m_addr);
        chk({tag, ".depth"}, int'(depth),    m_stack.size());
        chk({tag, ".ovf"},   int'(ovf),      m_ovf);
        chk({tag, ".unf"},   int'(unf),      m_unf);
        chk({tag, ".err"},   int'(op_err),   m_err);
    endtask

    initial begin
        m_page = 0; m_ovf = 0; m_unf = 0; m_err = 0; m_addr = 0;
        #1;
        step("rst0", 1, 1, 3, 1, 0, 4'hF);
        step("rst1", 1, 0, 0, 0, 0, 0);
        // idle with lower {3,1}
        step("idle", 0, 0, 0, 0, 0, 4'b1101);
        // set page 2 with lower {1,0}: bypass into same-cycle address
        step("setpa", 0, 1, 2, 0, 0, 4'b0100);
        // page 1, then call into page 3, then return
        step("pg1",  0, 1, 1, 0, 0, 4'b0110);
        step("call", 0, 1, 3, 1, 0, 4'b0110);
        step("ret",  0, 1, 2, 0, 1, 4'b1011);
        // fill, overflow, drain, underflow
        for (int i = 0; i < SD; i++) step("fill", 0, 1, i, 1, 0, i);
        step("ovf",   0, 1, 1, 1, 0, 4'b0011);
        step("ovfclr",0, 0, 0, 0, 0, 4'b0011);
        for (int i = 0; i < SD; i++) step("drain", 0, 0, 0, 0, 1, i);
        step("unf",   0, 0, 0, 0, 1, 4'b1001);
        step("unfset",0, 1, 3, 0, 1, 4'b1001);
        // push and pop together with a page load
        step("pp0",   0, 0, 0, 1, 0, 0);
        step("pperr", 0, 1, 2, 1, 1, 4'b0101);
        // mid-sequence reset with depth 3
        step("d1", 0, 0, 0, 1, 0, 1);
        step("d2", 0, 0, 0, 1, 0, 2);
        step("rstmid", 1, 1, 3, 1, 0, 3);
        step("after", 0, 0, 0, 0, 0, 3);
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int ops;
            ops = $urandom_range(0, 9);
            step("rnd", ($urandom_range(0, 63) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 3), (ops < 4) || (ops == 9), (ops >= 4 && ops < 8) || (ops == 9),
                 $urandom_range(0, 15));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
